// File: rtl/intr_ctrl.sv
// Four-source interrupt controller: edge-detects sources into PEND, arbitrates the lowest
// enabled pending source onto intr0 (timer) or intr1 (others) and holds it through service.
module intr_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter logic [31:0] VEC0      = 32'h0000_0008,
    parameter logic [31:0] VEC1      = 32'h0000_0010
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  irq_src,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] m_addr,
    input  logic [31:0] d_t_mem,
    input  logic        wmem,
    input  logic        rmem,
    output logic        intr0,
    output logic        intr1,
    output logic        irq_sel,
    output logic [31:0] irq_rdata
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StService = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  prev_q;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  ovf_q, ovf_d;
    logic [1:0]  cause_q, cause_d;
    logic        intr0_q, intr0_d;
    logic        intr1_q, intr1_d;

    logic        wr_en;
    logic        wr_pend, wr_mask, wr_eoi;
    logic [3:0]  rise;
    logic [3:0]  pend_eff;
    logic [3:0]  avail;
    logic [1:0]  grant_idx;
    logic [31:0] vec_addr;
    logic        unused_bits;

    assign unused_bits = ^d_t_mem[31:4];

    assign irq_sel = (m_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = irq_sel & wmem;
    assign wr_pend = wr_en & (m_addr[3:0] == 4'h0);
    assign wr_mask = wr_en & (m_addr[3:0] == 4'h4);
    assign wr_eoi  = wr_en & (m_addr[3:0] == 4'hC);

    assign rise = irq_src & ~prev_q;

    // W1C applied before the new edges so a simultaneous edge keeps the bit set.
    assign pend_eff = (pend_q & ~(wr_pend ? d_t_mem[3:0] : 4'b0000)) | rise;
    assign avail    = pend_eff & mask_q;

    always_comb begin
        grant_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (avail[i]) begin
                grant_idx = i[1:0];
            end
        end
    end

    assign vec_addr = (cause_q == 2'd0) ? VEC0 : VEC1;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_eff;
        mask_d  = wr_mask ? d_t_mem[3:0] : mask_q;
        ovf_d   = ovf_q;
        cause_d = cause_q;
        intr0_d = intr0_q;
        intr1_d = intr1_q;

        if (|(rise & pend_q) && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (|avail) begin
                    cause_d           = grant_idx;
                    pend_d[grant_idx] = 1'b0;
                    intr0_d           = (grant_idx == 2'd0);
                    intr1_d           = (grant_idx != 2'd0);
                    state_d           = StAssert;
                end
            end
            StAssert: begin
                if (cpu_pc == vec_addr) begin
                    intr0_d = 1'b0;
                    intr1_d = 1'b0;
                    state_d = StService;
                end
            end
            StService: begin
                if (wr_eoi) begin
                    state_d = StIdle;
                end
            end
            default: begin
                intr0_d = 1'b0;
                intr1_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // No reset: clocking during reset tracks irq_src, so sources held high across reset
    // do not register as edges once reset is released.
    always_ff @(posedge clock) begin
        prev_q <= irq_src;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            pend_q  <= 4'b0000;
            mask_q  <= 4'b0011;
            ovf_q   <= 8'd0;
            cause_q <= 2'd0;
            intr0_q <= 1'b0;
            intr1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            cause_q <= cause_d;
            intr0_q <= intr0_d;
            intr1_q <= intr1_d;
        end
    end

    assign intr0 = intr0_q;
    assign intr1 = intr1_q;

    always_comb begin
        irq_rdata = 32'd0;
        if (irq_sel && rmem) begin
            case (m_addr[3:0])
                4'h0:    irq_rdata = {28'd0, pend_q};
                4'h4:    irq_rdata = {28'd0, mask_q};
                4'h8:    irq_rdata = {16'd0, ovf_q, 2'b00, state_q, 2'b00, cause_q};
                default: irq_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a per-cycle vector table plus hand sequences for reset
// during ASSERT and address decode.
module tb_intr_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  irq_src;
    logic [31:0] cpu_pc;
    logic [31:0] m_addr;
    logic [31:0] d_t_mem;
    logic        wmem;
    logic        rmem;
    logic        intr0;
    logic        intr1;
    logic        irq_sel;
    logic [31:0] irq_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    intr_ctrl dut (
        .clock     (clock),
        .resetn    (resetn),
        .irq_src   (irq_src),
        .cpu_pc    (cpu_pc),
        .m_addr    (m_addr),
        .d_t_mem   (d_t_mem),
        .wmem      (wmem),
        .rmem      (rmem),
        .intr0     (intr0),
        .intr1     (intr1),
        .irq_sel   (irq_sel),
        .irq_rdata (irq_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  off;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  src;
        logic [31:0] pc;
        logic        e_i0;
        logic        e_i1;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] off, input logic wr, input logic rd,
                                input logic [31:0] wdata, input logic [3:0] src,
                                input logic [31:0] pc, input logic e_i0, input logic e_i1,
                                input logic [31:0] e_rd);
        vec_t v;
        v.off = off; v.wr = wr; v.rd = rd; v.wdata = wdata; v.src = src; v.pc = pc;
        v.e_i0 = e_i0; v.e_i1 = e_i1; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Combinational read away from the clock edge.
    task automatic rd_chk(input string name, input logic [31:0] addr, input logic exp_sel,
                          input logic [31:0] exp);
        m_addr = addr;
        rmem   = 1'b1;
        #1;
        chk({name, "_sel"}, {31'd0, irq_sel}, {31'd0, exp_sel});
        chk(name, irq_rdata, exp);
        rmem   = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        irq_src = 4'b0000;
        cpu_pc  = 32'd0;
        m_addr  = 32'd0;
        d_t_mem = 32'd0;
        wmem    = 1'b0;
        rmem    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        chk("rst_intr0", {31'd0, intr0}, 32'd0);
        chk("rst_intr1", {31'd0, intr1}, 32'd0);
        rd_chk("rst_mask", BASE + 32'h4, 1'b1, 32'h3);
        rd_chk("rst_stat", BASE + 32'h8, 1'b1, 32'h0);
        rd_chk("rst_pend", BASE + 32'h0, 1'b1, 32'h0);

        //           off   wr    rd    wdata  src      pc     i0    i1    rdata
        // timer edge -> ASSERT, vector entry -> SERVICE, EOI -> IDLE
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0001, 32'h00, 1'b1, 1'b0, 32'h0010));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0001, 32'h08, 1'b0, 1'b0, 32'h0020));
        vecs.push_back(mk(4'hC, 1'b1, 1'b0, 32'h0, 4'b0001, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0001, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'h0, 4'b0000, 32'h00, 1'b0, 1'b0, 32'h0000));
        // two simultaneous edges: lowest index wins, other stays pending
        vecs.push_back(mk(4'h4, 1'b1, 1'b0, 32'hF, 4'b0000, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h4, 1'b0, 1'b1, 32'h0, 4'b0000, 32'h00, 1'b0, 1'b0, 32'h000F));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0110, 32'h00, 1'b0, 1'b1, 32'h0011));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'h0, 4'b0110, 32'h00, 1'b0, 1'b1, 32'h0004));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0110, 32'h10, 1'b0, 1'b0, 32'h0021));
        vecs.push_back(mk(4'hC, 1'b1, 1'b0, 32'h0, 4'b0110, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0110, 32'h00, 1'b0, 1'b1, 32'h0012));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0110, 32'h10, 1'b0, 1'b0, 32'h0022));
        vecs.push_back(mk(4'hC, 1'b1, 1'b0, 32'h0, 4'b0000, 32'h00, 1'b0, 1'b0, 32'h0000));
        // masked source stays pending until MASK is set
        vecs.push_back(mk(4'h4, 1'b1, 1'b0, 32'h0, 4'b0000, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'h0, 4'b0001, 32'h00, 1'b0, 1'b0, 32'h0001));
        vecs.push_back(mk(4'h4, 1'b1, 1'b0, 32'h1, 4'b0001, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'h0, 4'b0001, 32'h00, 1'b1, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h0, 1'b0, 1'b0, 32'h0, 4'b0001, 32'h08, 1'b0, 1'b0, 32'h0000));
        // keyboard edges in SERVICE: overflow count, set beats W1C
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'h0, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0002));
        vecs.push_back(mk(4'h0, 1'b0, 1'b0, 32'h0, 4'b0001, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0120));
        vecs.push_back(mk(4'h0, 1'b0, 1'b0, 32'h0, 4'b0001, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h0, 1'b1, 1'b0, 32'h2, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'h0, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0002));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0220));
        // EOI back to IDLE; masked keyboard stays pending, vector match in IDLE ignored
        vecs.push_back(mk(4'hC, 1'b1, 1'b0, 32'h0, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0000));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0011, 32'h00, 1'b0, 1'b0, 32'h0200));
        vecs.push_back(mk(4'h8, 1'b0, 1'b1, 32'h0, 4'b0011, 32'h08, 1'b0, 1'b0, 32'h0200));

        foreach (vecs[i]) begin
            @(negedge clock);
            m_addr  = BASE + {28'd0, vecs[i].off};
            wmem    = vecs[i].wr;
            rmem    = vecs[i].rd;
            d_t_mem = vecs[i].wdata;
            irq_src = vecs[i].src;
            cpu_pc  = vecs[i].pc;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_intr0", i), {31'd0, intr0}, {31'd0, vecs[i].e_i0});
            chk($sformatf("v%0d_intr1", i), {31'd0, intr1}, {31'd0, vecs[i].e_i1});
            chk($sformatf("v%0d_rdata", i), irq_rdata, vecs[i].e_rd);
        end

        // Enable keyboard so the pending bit reaches ASSERT, then reset mid-ASSERT.
        @(negedge clock);
        rmem    = 1'b0;
        cpu_pc  = 32'd0;
        m_addr  = BASE + 32'h4;
        d_t_mem = 32'h3;
        wmem    = 1'b1;
        @(posedge clock);
        #1;
        chk("mask_wr_intr1", {31'd0, intr1}, 32'd0);
        @(negedge clock);
        wmem = 1'b0;
        @(posedge clock);
        #1;
        chk("kbd_assert_intr1", {31'd0, intr1}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_intr0", {31'd0, intr0}, 32'd0);
        chk("rst_async_intr1", {31'd0, intr1}, 32'd0);
        rd_chk("rst_async_stat", BASE + 32'h8, 1'b1, 32'h0);
        rd_chk("rst_async_mask", BASE + 32'h4, 1'b1, 32'h3);
        rd_chk("rst_async_pend", BASE + 32'h0, 1'b1, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_intr0", {31'd0, intr0}, 32'd0);
        chk("post_rst_intr1", {31'd0, intr1}, 32'd0);
        @(negedge clock);
        rd_chk("post_rst_pend", BASE + 32'h0, 1'b1, 32'h0);
        rd_chk("post_rst_stat", BASE + 32'h8, 1'b1, 32'h0);

        // Address decode boundaries
        rd_chk("dec_mask", BASE + 32'h4, 1'b1, 32'h3);
        rd_chk("dec_out", BASE + 32'h10, 1'b0, 32'h0);
        rd_chk("dec_below", BASE - 32'h4, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
